// File: rtl/nn_pkg.sv
// Shared defaults and state encoding for the output-memory write scheduler.
package nn_pkg;

    localparam int DEF_NUM_LANES   = 4;
    localparam int DEF_DATA_W      = 16;
    localparam int DEF_ADDR_W      = 3;
    localparam int DEF_NUM_OUTPUTS = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } sched_state_t;

    // Width of a lane index; a single lane still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requesting lane at or after ptr wins.
module rr_arbiter
    import nn_pkg::*;
#(
    parameter int NUM_LANES = DEF_NUM_LANES,
    parameter int IDX_W     = idx_width(NUM_LANES)
) (
    input  logic [NUM_LANES-1:0] req,
    input  logic [IDX_W-1:0]     ptr,
    output logic [NUM_LANES-1:0] grant,
    output logic [IDX_W-1:0]     grant_idx,
    output logic                 grant_valid
);

    logic [IDX_W-1:0] cand;

    // NOTE: every output gets a default before the search loop, so no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        cand        = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            cand = IDX_W'((int'(ptr) + k) % NUM_LANES);
            if (!grant_valid && req[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
        if (grant_valid) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/dom_write_scheduler.sv
// Collects lane results and writes them round-robin into the output memory.
// Define DOM_RELU_EN to zero negative elements on their way to memory.
module dom_write_scheduler
    import nn_pkg::*;
#(
    parameter int NUM_LANES   = DEF_NUM_LANES,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int NUM_OUTPUTS = DEF_NUM_OUTPUTS
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        xxx__dut__go,
    input  logic [NUM_LANES*DATA_W-1:0] lane_element,
    input  logic [NUM_LANES-1:0]        lane_element_ready,
    output logic [ADDR_W-1:0]           dut__dom__address,
    output logic [DATA_W-1:0]           dut__dom__data,
    output logic                        dut__dom__enable,
    output logic                        dut__dom__write,
    output logic                        dut__xxx__finish,
    output logic                        busy,
    output logic                        overflow
);

    localparam int IDX_W = idx_width(NUM_LANES);
    localparam int CNT_W = $clog2(NUM_OUTPUTS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_OUTPUTS);

    sched_state_t          state;
    logic [NUM_LANES-1:0]  pending;
    logic [NUM_LANES-1:0]  next_pending;
    logic [NUM_LANES-1:0]  capture;
    logic [NUM_LANES-1:0]  req;
    logic [NUM_LANES-1:0]  grant;
    logic [DATA_W-1:0]     hold [NUM_LANES];
    logic [IDX_W-1:0]      ptr;
    logic [IDX_W-1:0]      grant_idx;
    logic                  grant_valid;
    logic                  in_collect;
    logic                  full;
    logic                  overrun;
    logic [CNT_W-1:0]      count;
    logic [DATA_W-1:0]     held;
    logic [DATA_W-1:0]     write_value;

    assign in_collect = (state == COLLECT);
    assign full       = (count == LAST_CNT);
    assign req        = (in_collect && !full) ? pending : '0;

    rr_arbiter #(
        .NUM_LANES (NUM_LANES),
        .IDX_W     (IDX_W)
    ) u_arb (
        .req         (req),
        .ptr         (ptr),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    // A lane being granted this cycle frees its slot, so a same-cycle refill is accepted.
    assign capture      = in_collect ? (lane_element_ready & (~pending | grant)) : '0;
    assign next_pending = capture | (pending & ~grant);
    assign overrun      = in_collect && (|(lane_element_ready & pending & ~grant));

    assign held = hold[grant_idx];
`ifdef DOM_RELU_EN
    assign write_value = held[DATA_W-1] ? '0 : held;
`else
    assign write_value = held;
`endif

    // NOTE: holding registers carry no reset; pending[i] qualifies every read, so their power-up contents never reach memory.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_LANES; i++) begin
            if (capture[i]) begin
                hold[i] <= lane_element[i*DATA_W +: DATA_W];
            end
        end
    end

    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state             <= IDLE;
            pending           <= '0;
            ptr               <= '0;
            count             <= '0;
            overflow          <= 1'b0;
            busy              <= 1'b0;
            dut__xxx__finish  <= 1'b0;
            dut__dom__address <= '0;
            dut__dom__data    <= '0;
            dut__dom__enable  <= 1'b0;
            dut__dom__write   <= 1'b0;
        end else begin
            dut__dom__enable <= 1'b0;
            dut__dom__write  <= 1'b0;
            case (state)
                IDLE: begin
                    if (xxx__dut__go) begin
                        state    <= COLLECT;
                        busy     <= 1'b1;
                        pending  <= '0;
                        ptr      <= '0;
                        count    <= '0;
                        overflow <= 1'b0;
                    end
                end
                COLLECT: begin
                    overflow <= overflow | overrun;
                    if (full) begin
                        // Final write is on the bus this cycle; leftovers are dropped.
                        state            <= DONE;
                        busy             <= 1'b0;
                        dut__xxx__finish <= 1'b1;
                        pending          <= '0;
                    end else begin
                        pending <= next_pending;
                        if (grant_valid) begin
                            dut__dom__enable  <= 1'b1;
                            dut__dom__write   <= 1'b1;
                            dut__dom__address <= ADDR_W'(count);
                            dut__dom__data    <= write_value;
                            count             <= count + 1'b1;
                            ptr               <= (grant_idx == IDX_W'(NUM_LANES - 1)) ? '0 : grant_idx + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state            <= IDLE;
                    dut__xxx__finish <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
